// File: rtl/q_next_max_fp.sv
// q_next_max_fp: scans one Q-table row through a 1-cycle-latency read port and
// reports the FP32 row maximum and its action index with a start/done handshake.
module q_next_max_fp #(
  parameter int NUM_STATES  = 16,
  parameter int NUM_ACTIONS = 4,
  parameter int STATE_W     = $clog2(NUM_STATES),
  parameter int ACT_W       = $clog2(NUM_ACTIONS),
  parameter int ADDR_W      = $clog2(NUM_STATES*NUM_ACTIONS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [STATE_W-1:0] state,
  input  logic               terminal,
  output logic               q_rd_en,
  output logic [ADDR_W-1:0]  q_rd_addr,
  input  logic [31:0]        q_rd_data,
  output logic [31:0]        next_max,
  output logic [ACT_W-1:0]   best_action,
  output logic               err,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
  localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(NUM_ACTIONS-1);

  state_t              r_fsm, w_fsm_next;
  logic                w_accept, w_bad_in, w_rd_en_next;
  logic [ADDR_W-1:0]   w_base_in, w_rd_addr_next;
  logic [ACT_W-1:0]    w_act_next;

  logic [ADDR_W-1:0]   r_base;
  logic                r_bad;
  logic [ACT_W-1:0]    r_act;
  logic                r_cmp_vld;
  logic [ACT_W-1:0]    r_cmp_idx;
  logic [31:0]         r_max;
  logic [ACT_W-1:0]    r_max_idx;
  logic                r_max_nan;
  logic [31:0]         w_max_upd;
  logic [ACT_W-1:0]    w_max_idx_upd;
  logic                w_max_nan_upd;
  logic                w_replace;

  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [31:0]         r_next_max;
  logic [ACT_W-1:0]    r_best;
  logic                r_err, r_busy, r_done;

  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotonic unsigned key for IEEE-754 ordering; -0 folds onto +0.
  function automatic logic [31:0] f_key(input logic [31:0] x);
    logic [31:0] v;
    v = (x == 32'h8000_0000) ? 32'h0000_0000 : x;
    return v[31] ? ~v : (v ^ 32'h8000_0000);
  endfunction

  assign w_base_in = ADDR_W'(state) * ADDR_W'(NUM_ACTIONS);
  assign w_bad_in  = (32'(state) >= 32'(NUM_STATES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_next;
  end

  // Rows with no reads pass through DRAIN so done lands two cycles after start.
  always_comb begin
    w_fsm_next     = r_fsm;
    w_accept       = 1'b0;
    w_rd_en_next   = 1'b0;
    w_rd_addr_next = r_rd_addr;
    w_act_next     = r_act;
    case (r_fsm)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (terminal || w_bad_in) begin
            w_fsm_next = S_DRAIN;
          end else begin
            w_fsm_next     = S_READ;
            w_rd_en_next   = 1'b1;
            w_rd_addr_next = w_base_in;
            w_act_next     = '0;
          end
        end
      end
      S_READ: begin
        if (r_act == LAST_ACT) begin
          w_fsm_next = S_DRAIN;
        end else begin
          w_rd_en_next   = 1'b1;
          w_act_next     = r_act + ACT_W'(1);
          w_rd_addr_next = r_base + ADDR_W'(r_act) + ADDR_W'(1);
        end
      end
      S_DRAIN: w_fsm_next = S_DONE;
      S_DONE:  w_fsm_next = S_IDLE;
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // Index 0 seeds the running max; a NaN max yields to any real candidate.
  always_comb begin
    w_replace     = !f_is_nan(q_rd_data) &&
                    (r_max_nan || (f_key(q_rd_data) > f_key(r_max)));
    w_max_upd     = r_max;
    w_max_idx_upd = r_max_idx;
    w_max_nan_upd = r_max_nan;
    if (r_cmp_vld && ((r_cmp_idx == '0) || w_replace)) begin
      w_max_upd     = q_rd_data;
      w_max_idx_upd = r_cmp_idx;
      w_max_nan_upd = f_is_nan(q_rd_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_bad      <= 1'b0;
      r_act      <= '0;
      r_cmp_vld  <= 1'b0;
      r_cmp_idx  <= '0;
      r_max      <= '0;
      r_max_idx  <= '0;
      r_max_nan  <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_next_max <= '0;
      r_best     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en_next;
      r_rd_addr <= w_rd_addr_next;
      r_act     <= w_act_next;
      r_busy    <= (w_fsm_next != S_IDLE);
      r_done    <= (w_fsm_next == S_DONE);
      r_cmp_vld <= r_rd_en;
      r_cmp_idx <= r_act;
      if (w_accept) begin
        r_base    <= w_base_in;
        r_bad     <= w_bad_in;
        r_max     <= '0;
        r_max_idx <= '0;
        r_max_nan <= 1'b0;
      end else begin
        r_max     <= w_max_upd;
        r_max_idx <= w_max_idx_upd;
        r_max_nan <= w_max_nan_upd;
      end
      if (r_fsm == S_DRAIN) begin
        r_next_max <= w_max_nan_upd ? QNAN : w_max_upd;
        r_best     <= w_max_idx_upd;
        r_err      <= r_bad;
      end
    end
  end

  assign q_rd_en     = r_rd_en;
  assign q_rd_addr   = r_rd_addr;
  assign next_max    = r_next_max;
  assign best_action = r_best;
  assign err         = r_err;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_q_next_max_fp.sv
// Directed bench for q_next_max_fp: row scans, FP ordering corner cases,
// terminal/invalid states, start while busy and asynchronous reset mid-scan.
module tb_q_next_max_fp;

  localparam int NS = 16;
  localparam int NA = 4;
  localparam int SW = 5;
  localparam int AW = 2;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          terminal = 1'b0;
  logic [SW-1:0] state = '0;
  logic          q_rd_en;
  logic [DW-1:0] q_rd_addr;
  logic [31:0]   q_rd_data = '0;
  logic [31:0]   next_max;
  logic [AW-1:0] best_action;
  logic          err, busy, done;

  logic [31:0] mem [0:63];
  int n_tests = 0;
  int n_fail  = 0;
  int rd_addr_q[$];
  int rd_cyc_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (q_rd_en) q_rd_data <= mem[q_rd_addr];

  q_next_max_fp #(
    .NUM_STATES (NS),
    .NUM_ACTIONS(NA),
    .STATE_W    (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .state      (state),
    .terminal   (terminal),
    .q_rd_en    (q_rd_en),
    .q_rd_addr  (q_rd_addr),
    .q_rd_data  (q_rd_data),
    .next_max   (next_max),
    .best_action(best_action),
    .err        (err),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Start is sampled on the posedge following this call (cycle 0 edge).
  task automatic issue(input logic [SW-1:0] st, input logic term, input bit hold);
    @(negedge clk);
    check("idle_done_low", 32'(done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
    start = 1'b1;
    state = st;
    terminal = term;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    rd_addr_q.delete();
    rd_cyc_q.delete();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (q_rd_en) begin
        rd_addr_q.push_back(int'(q_rd_addr));
        rd_cyc_q.push_back(k);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic req(input string tag, input logic [SW-1:0] st, input logic term, input bit hold,
                     input logic [31:0] e_max, input int e_best, input int e_err,
                     input int e_lat, input int e_nrd);
    int lat;
    issue(st, term, hold);
    wait_done(lat);
    check({tag, "_lat"},  32'(lat), 32'(e_lat));
    check({tag, "_max"},  next_max, e_max);
    check({tag, "_best"}, 32'(best_action), 32'(e_best));
    check({tag, "_err"},  32'(err), 32'(e_err));
    check({tag, "_nrd"},  32'(rd_addr_q.size()), 32'(e_nrd));
    for (int i = 0; i < rd_addr_q.size() && i < e_nrd; i++) begin
      check({tag, "_addr"}, 32'(rd_addr_q[i]), 32'(int'(st) * NA + i));
      check({tag, "_rdcyc"}, 32'(rd_cyc_q[i]), 32'(i + 1));
    end
    $display("[TB] %s: state=%0d term=%0b next_max=%h best=%0d err=%0b lat=%0d reads=%0d",
             tag, st, term, next_max, best_action, err, lat, rd_addr_q.size());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   32'(q_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(q_rd_addr), 32'd0);
    check({tag, "_max"},     next_max, 32'd0);
    check({tag, "_best"},    32'(best_action), 32'd0);
    check({tag, "_err"},     32'(err), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1234_0000 + 32'(i);
    // row 5: 1.0, 2.0, 0.5, -1.0
    mem[20] = 32'h3F80_0000; mem[21] = 32'h4000_0000; mem[22] = 32'h3F00_0000; mem[23] = 32'hBF80_0000;
    // row 2: +0, +0, -0, +0
    mem[8]  = 32'h0000_0000; mem[9]  = 32'h0000_0000; mem[10] = 32'h8000_0000; mem[11] = 32'h0000_0000;
    // row 3: NaN, -3.0, -2.0, NaN
    mem[12] = 32'h7FC0_0000; mem[13] = 32'hC040_0000; mem[14] = 32'hC000_0000; mem[15] = 32'h7FC0_0000;
    // row 7: assorted NaNs
    mem[28] = 32'h7FC0_0001; mem[29] = 32'hFFC0_0000; mem[30] = 32'h7F80_0001; mem[31] = 32'h7FFF_FFFF;
    // row 9: -Inf, +Inf, max finite, +Inf
    mem[36] = 32'hFF80_0000; mem[37] = 32'h7F80_0000; mem[38] = 32'h7F7F_FFFF; mem[39] = 32'h7F80_0000;
    // row 10: -1.0, -2.0, -0, smallest denormal
    mem[40] = 32'hBF80_0000; mem[41] = 32'hC000_0000; mem[42] = 32'h8000_0000; mem[43] = 32'h0000_0001;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    req("t1_basic",   5'd5,  1'b0, 1'b0, 32'h4000_0000, 1, 0, 6, 4);
    req("t2_zeros",   5'd2,  1'b0, 1'b0, 32'h0000_0000, 0, 0, 6, 4);
    req("t3_nanmix",  5'd3,  1'b0, 1'b0, 32'hC000_0000, 2, 0, 6, 4);
    req("t3_allnan",  5'd7,  1'b0, 1'b0, 32'h7FC0_0000, 0, 0, 6, 4);
    req("t_inf",      5'd9,  1'b0, 1'b0, 32'h7F80_0000, 1, 0, 6, 4);
    req("t_neg",      5'd10, 1'b0, 1'b0, 32'h0000_0001, 3, 0, 6, 4);
    req("t4_term",    5'd5,  1'b1, 1'b0, 32'h0000_0000, 0, 0, 2, 0);
    req("t4_badst",   5'd16, 1'b0, 1'b0, 32'h0000_0000, 0, 1, 2, 0);

    // start held high for the whole scan including the done cycle
    req("t5_hold",    5'd5,  1'b0, 1'b1, 32'h4000_0000, 1, 0, 6, 4);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_done_after", 32'(done), 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_extra_done", 32'(ndone), 32'd0);

    // asynchronous reset during the read of action 2
    issue(5'd5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("t6_addr_a2", 32'(q_rd_addr), 32'd22);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t6_no_done", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    req("t6_fresh",   5'd5,  1'b0, 1'b0, 32'h4000_0000, 1, 0, 6, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
